// File: rtl/lp_calc_pkg.sv
// Shared definitions for the calculator result display engine.
// Optional leading-zero blanking is enabled by defining LP_CALC_DISP_LZB_EN.
package lp_calc_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned DAB_STEPS  = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned VAL_W      = 8;
    localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned STEP_W     = 3;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
    function automatic logic [BCD_W-1:0] dab_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] r;
        r = acc;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (acc[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
                r[i*DIGIT_W +: DIGIT_W] = acc[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
        end
        return r;
    endfunction

endpackage

// File: rtl/lp_calc_seg7.sv
// BCD digit to active-low 7-segment code; non-decimal codes are blank.
module lp_calc_seg7
    import lp_calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [SEG_W-1:0]   seg_c
);

    // Pure lookup, no state
    always_comb begin
        seg_c = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lp_calc_disp.sv
// Result display engine: iterative binary-to-BCD conversion (one shift per
// cycle) feeding a multiplexed active-low 3-digit 7-segment display.
// Define LP_CALC_DISP_LZB_EN to blank leading zeros.
module lp_calc_disp
    import lp_calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [VAL_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd,
    output logic [SEG_W-1:0]  seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_e               state_q, state_d;
    logic                 req_q, req_d;
    logic [VAL_W-1:0]     res_q, res_d;
    logic [VAL_W-1:0]     shreg_q, shreg_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [VAL_W-1:0]     last_q, last_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [DIGIT_W-1:0]   digit_sel;
    logic [SEG_W-1:0]     seg_dec_c;
    logic                 show;

    // All state registers; reset blanks the display and forgets the last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            res_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            res_q   <= res_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Conversion FSM; start/result are captured in IDLE and acted on next cycle
    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        res_d   = res_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (state_q == ST_IDLE && !req_q && start) begin
            req_d = 1'b1;
            res_d = result;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_q) begin
                    if (valid_q && (res_q == last_q)) begin
                        done_d = 1'b1;
                    end else begin
                        shreg_d = res_q;
                        acc_d   = '0;
                        step_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                {acc_d, shreg_d} = {dab_adjust(acc_q), shreg_q} << 1;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(DAB_STEPS - 1))
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bcd_d   = acc_q;
                last_d  = res_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Digit currently selected by the scan index
    always_comb begin
        digit_sel = '0;
        case (idx_q)
            2'd0:    digit_sel = bcd_q[0*DIGIT_W +: DIGIT_W];
            2'd1:    digit_sel = bcd_q[1*DIGIT_W +: DIGIT_W];
            default: digit_sel = bcd_q[2*DIGIT_W +: DIGIT_W];
        endcase
    end

    lp_calc_seg7 u_seg7 (
        .digit_i (digit_sel),
        .seg_c   (seg_dec_c)
    );

    // Free-running scan and registered anode/segment drive
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        show = valid_q;
`ifdef LP_CALC_DISP_LZB_EN
        if (idx_q == 2'd2 && bcd_q[2*DIGIT_W +: DIGIT_W] == '0)
            show = 1'b0;
        if (idx_q == 2'd1 && bcd_q[2*DIGIT_W +: DIGIT_W] == '0
                          && bcd_q[1*DIGIT_W +: DIGIT_W] == '0)
            show = 1'b0;
`endif

        an_d  = show ? ~(3'b001 << idx_q) : 3'b111;
        seg_d = show ? seg_dec_c : SEG_BLANK;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_lp_calc_disp.sv
// Randomized self-checking bench for lp_calc_disp against a decimal-arithmetic
// reference model. Honors LP_CALC_DISP_LZB_EN the same way as the design.
module tb_lp_calc_disp;

    localparam int unsigned SD = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  result;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_cmp;
    int n_err;
    int ecnt;

    // Reference model state
    logic [11:0] m_bcd;
    logic [7:0]  m_last;
    bit          m_valid;
    logic [6:0]  seg_tab [0:15];

    lp_calc_disp #(.SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .result (result),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release, used to derive the expected scan slot
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_bcd"},  32'(bcd),  32'h000);
        chk({tag, "_an"},   32'(an),   32'h7);
        chk({tag, "_seg"},  32'(seg),  32'h7F);
    endtask

    // Check the multiplexed display for n cycles while the value is stable
    task automatic disp_check(input int n);
        int idx;
        logic [3:0] dig;
        logic [2:0] e_an;
        logic [6:0] e_seg;
        bit show;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            idx  = (ecnt > 0) ? ((ecnt - 1) / int'(SD)) % 3 : 0;
            dig  = m_bcd[idx*4 +: 4];
            show = m_valid;
`ifdef LP_CALC_DISP_LZB_EN
            if (idx == 2 && m_bcd[11:8] == 4'd0) show = 0;
            if (idx == 1 && m_bcd[11:4] == 8'd0) show = 0;
`endif
            e_an  = show ? ~(3'b001 << idx) : 3'b111;
            e_seg = show ? seg_tab[dig] : 7'h7F;
            chk("scan_an",  32'(an),  32'(e_an));
            chk("scan_seg", 32'(seg), 32'(e_seg));
        end
    endtask

    // One start request with a start pulse of value pv injected while busy
    task automatic convert(input logic [7:0] v, input logic [7:0] pv);
        bit fast;
        logic [11:0] old;
        int kp;
        fast = m_valid && (v == m_last);
        old  = m_bcd;
        @(negedge clk);
        start  = 1'b1;
        result = v;
        @(negedge clk);
        start  = 1'b0;
        result = 8'($urandom);
        chk("busy_n0", 32'(busy), 32'd0);
        chk("done_n0", 32'(done), 32'd0);
        if (fast) begin
            @(negedge clk);
            chk("fast_done", 32'(done), 32'd1);
            chk("fast_busy", 32'(busy), 32'd0);
            chk("fast_bcd",  32'(bcd),  32'(old));
            @(negedge clk);
            chk("fast_done_clr", 32'(done), 32'd0);
            chk("fast_busy2",    32'(busy), 32'd0);
        end else begin
            kp = $urandom_range(1, 9);
            for (int k = 1; k <= 9; k++) begin
                @(negedge clk);
                start = 1'b0;
                chk("conv_busy", 32'(busy), 32'd1);
                chk("conv_done", 32'(done), 32'd0);
                chk("conv_hold", 32'(bcd),  32'(old));
                if (k == kp) begin
                    start  = 1'b1;
                    result = pv;
                end
            end
            @(negedge clk);
            start = 1'b0;
            m_bcd   = to_bcd(int'(v));
            m_last  = v;
            m_valid = 1'b1;
            chk("load_done", 32'(done), 32'd1);
            chk("load_busy", 32'(busy), 32'd0);
            chk("load_bcd",  32'(bcd),  32'(m_bcd));
            @(negedge clk);
            chk("done_clr",  32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic model_reset();
        m_bcd   = '0;
        m_last  = '0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        n_cmp = 0;
        n_err = 0;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;
        model_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        result = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst_held");
        rst_n = 1'b1;
        disp_check(3 * int'(SD) + 2);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_idle_bcd",  32'(bcd),  32'h000);

        convert(8'd255, 8'd17);
        disp_check(3 * int'(SD) + 1);
        convert(8'd254, 8'd3);
        convert(8'd4, 8'd99);
        convert(8'd4, 8'd42);
        disp_check(3 * int'(SD));

        // Reset partway through the shift sequence
        @(negedge clk);
        start  = 1'b1;
        result = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        disp_check(2 * int'(SD));
        convert(8'd128, 8'd5);
        disp_check(3 * int'(SD));

        convert(8'd7, 8'd70);
        disp_check(3 * int'(SD) + 2);
        convert(8'd0, 8'd1);
        disp_check(3 * int'(SD));
        convert(8'd0, 8'd2);

        for (int i = 0; i < 25; i++) begin
            if (m_valid && $urandom_range(0, 3) == 0) v = m_last;
            else                                      v = 8'($urandom_range(0, 255));
            convert(v, 8'($urandom));
            if (i % 5 == 0) disp_check(3 * int'(SD));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lp_calc_disp.md
Name: lp_calc_disp

Overview:
Result-side display engine for the low-power 4-bit calculator. It takes the 8-bit arithmetic result and converts it to three BCD digits using an iterative double-dabble sequence of one shift per cycle. It then drives a time-multiplexed, active-low 3-digit 7-segment display. Re-conversion of an unchanged value is skipped to save switching power.

Parameters:
SCAN_DIV, 16, clock cycles each digit stays lit before the scan advances (>=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion of result; sampled only in IDLE
result  input  8  unsigned value to display (0..255); sampled only on an accepted start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: bcd updated
bcd  output  12  {hundreds,tens,units} BCD of last converted value
seg  output  7  {g,f,e,d,c,b,a}, active-low
an  output  3  digit anodes, active-low one-hot; an[0]=units, an[2]=hundreds

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - busy=0, done=0, bcd=12'h000
  - seg=7'h7F, an=3'b111 (display disabled)
  - scan counter=0, digit index=0
  - internal last_val=0, disp_valid=0
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - start=1 with disp_valid=1 and result==last_val (fast path): next cycle done=1; bcd unchanged; stay in IDLE; busy stays 0.
  - start=1 otherwise: latch result into the shift register, clear the BCD accumulator, go to SHIFT, busy=1.
- SHIFT: 8 cycles. Each cycle, add 3 to any accumulator nibble >=5, then shift {acc,shreg} left by 1. A 3-bit step counter goes to LOAD after step 8.
- LOAD:
  - bcd<=accumulator, last_val<=latched value, disp_valid<=1, done<=1, go to IDLE.
  - busy=0 from the LOAD exit.
- Slow-path timing: start sampled at edge N → busy=1 after N+1 … N+9; bcd valid and done=1 after edge N+10; done=0 after N+11.
- start while busy is ignored. result changes during SHIFT/LOAD are ignored.
- During conversion, bcd and the display keep the previous value (no flicker).
- Arithmetic: all values are unsigned. A wrapped subtraction such as 8'd254 is displayed as 254; there is no sign handling.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. At terminal count the digit index advances 0→1→2→0.
  - an=~(1<<index) and seg=decode(bcd digit[index]) only when disp_valid=1; otherwise an=111, seg=7F.
  - seg/an are registered (one-cycle lag from index change).
- Decoder: digits 0-9 use standard codes, e.g. 0=7'b1000000, 2=7'b0100100, 4=7'b0011001, 5=7'b0010010, 7=7'b1111000. Codes 10-15 map to blank 7'h7F.
- Reset mid-conversion: asynchronously aborts to the reset state; the display goes blank until the next completed conversion.

Optional Feature:
- Macro: LP_CALC_DISP_LZB_EN (leading-zero blanking).
- With the macro defined:
  - Hundreds digit is blanked when it is 0.
  - Tens digit is blanked when hundreds and tens are both 0.
  - Units digit is never blanked.
  - A blanked digit drives an[index]=1 and seg=7F during its slot; scan timing is unchanged.
- Without the macro: all three digits are always shown, e.g. 007.

Decomposition:
- Shared package lp_calc_pkg:
  - NUM_DIGITS=3, DAB_STEPS=8, BCD digit width 4
  - FSM state encoding (IDLE/SHIFT/LOAD)
  - 7-segment constants SEG_0..SEG_9 and SEG_BLANK
- One combinational sub-module, lp_calc_seg7: 4-bit BCD → 7-bit active-low segment code, with blank for values >9.

Test Plan:
1. Reset held then released → busy=0, done=0, bcd=000, an=111, seg=7F for ≥3·SCAN_DIV cycles.
2. start with result=255 → busy high 9 cycles; done pulse at edge N+10; bcd=12'h255; scan cycles an=110/101/011 with seg=SEG_5/SEG_5/SEG_2.
3. result=254 (3−5 wrap) → bcd=12'h254. Then start with result=4, pulsed while busy with result=99 → 99 ignored; bcd=12'h004 after the second conversion only.
4. Repeat start with result=4 → done after 1 cycle, busy never asserted, bcd unchanged.
5. Assert rst_n=0 at SHIFT step 4 → outputs return to reset values immediately; the next start with result=128 gives bcd=12'h128.
6. result=7:
   - LP_CALC_DISP_LZB_EN defined → an[2] and an[1] stay 1 in their slots; units shows seg=7'b1111000.
   - Macro undefined → digits show SEG_0, SEG_0, SEG_7.
